// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of imem_loader.
// The loader uses the slave modport; the stream source / memory model uses master.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: big-endian byte stream -> 32-bit instruction-memory writes, core held in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_rst_n,
    output logic         done,
    output logic         error
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        FIN    = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t          state_r;
    logic [15:0]     len_r;
    logic [23:0]     word_r;
    logic [ADDR_W:0] idx_r;
    logic [1:0]      cnt_r;
    logic            in_ready_r;
    logic            wr_en_r;
    logic [31:0]     wr_addr_r;
    logic [31:0]     wr_data_r;
    logic            core_rst_n_r;
    logic            done_r;
    logic            error_r;

    logic            accept_s;
    logic [15:0]     len_full_s;
    logic            len_bad_s;
    logic            last_word_s;
    logic [31:0]     word_next_s;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]      csum_r;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign accept_s    = bus.in_valid & in_ready_r;
    assign len_full_s  = {len_r[15:8], bus.in_data};
    assign len_bad_s   = (len_full_s == 16'd0) || (len_full_s > 16'(MAX_WORDS));
    assign last_word_s = (16'(idx_r) == (len_r - 16'd1));
    assign word_next_s = {word_r, bus.in_data};

    assign bus.in_ready     = in_ready_r;
    assign bus.imem_wr_en   = wr_en_r;
    assign bus.imem_wr_addr = wr_addr_r;
    assign bus.imem_wr_data = wr_data_r;
    assign core_rst_n       = core_rst_n_r;
    assign done             = done_r;
    assign error            = error_r;

    // Loader FSM: every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            len_r        <= 16'd0;
            word_r       <= 24'd0;
            idx_r        <= '0;
            cnt_r        <= 2'd0;
            in_ready_r   <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= 32'd0;
            wr_data_r    <= 32'd0;
            core_rst_n_r <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_r       <= 8'd0;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= LEN_HI;
                        in_ready_r   <= 1'b1;
                        core_rst_n_r <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (accept_s) begin
                        len_r[15:8] <= bus.in_data;
                        state_r     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept_s) begin
                        len_r[7:0] <= bus.in_data;
                        if (len_bad_s) begin
                            state_r    <= ERR;
                            in_ready_r <= 1'b0;
                            error_r    <= 1'b1;
                        end else begin
                            state_r <= DATA;
                            idx_r   <= '0;
                            cnt_r   <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
                            csum_r  <= 8'd0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        word_r <= word_next_s[23:0];
                        cnt_r  <= cnt_r + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_r <= csum_step(csum_r, bus.in_data);
`endif
                        if (cnt_r == 2'd3) begin
                            wr_en_r   <= 1'b1;
                            wr_addr_r <= 32'({idx_r[ADDR_W-1:0], 2'b00});
                            wr_data_r <= word_next_s;
                            idx_r     <= idx_r + 1'b1;
                            if (last_word_s) begin
`ifdef IMEM_LOADER_CSUM_EN
                                state_r    <= CSUM;
                                in_ready_r <= 1'b1;
`else
                                state_r    <= FIN;
                                in_ready_r <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CSUM: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (bus.in_data == csum_r) begin
                            state_r      <= DONE;
                            done_r       <= 1'b1;
                            core_rst_n_r <= 1'b1;
                        end else begin
                            state_r <= ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                FIN: begin
                    state_r      <= DONE;
                    done_r       <= 1'b1;
                    core_rst_n_r <= 1'b1;
                end
                DONE: begin
                    if (start) begin
                        state_r      <= LEN_HI;
                        in_ready_r   <= 1'b1;
                        done_r       <= 1'b0;
                        core_rst_n_r <= 1'b0;
                    end
                end
                ERR: begin
                    if (start) begin
                        state_r    <= LEN_HI;
                        in_ready_r <= 1'b1;
                        error_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    in_ready_r   <= 1'b0;
                    core_rst_n_r <= 1'b0;
                    done_r       <= 1'b0;
                    error_r      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stream-level reference model queues expected writes,
// a negedge monitor pops and compares them whenever imem_wr_en is seen.
module tb_imem_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_rst_n;
    logic done;
    logic error;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .core_rst_n(core_rst_n),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wr_gap = 0;
    int  last_wr_cyc = 0;
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        wr_t e;
        if (bus.imem_wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h (t=%0t)", bus.imem_wr_addr, bus.imem_wr_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_wr_addr !== e.addr || bus.imem_wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write actual=%h/%h expected=%h/%h", bus.imem_wr_addr, bus.imem_wr_data, e.addr, e.data);
                end
            end
            wr_gap      = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Drive a byte sequence; optional idle cycle before each byte. Returns at the negedge after the last accept.
    task automatic send(input logic [7:0] b[$], input bit toggle);
        int guard;
        for (int i = 0; i < b.size(); i++) begin
            if (toggle) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
                chk("ready_while_invalid", {31'd0, bus.in_ready}, 32'd1);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b[i];
            guard = 0;
            while (bus.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Reference model: builds the stream from the word list and predicts writes and final status.
    task automatic run_load(input int n, input logic [31:0] words[$], input bit toggle, input bit bad_csum);
        logic [7:0]  s[$];
        logic [7:0]  x;
        logic [7:0]  csum_byte;
        logic [15:0] n16;
        logic [31:0] w;
        bit          len_ok;
        bit          ok;
        int          lat;
        x      = 8'h00;
        n16    = 16'(n);
        len_ok = (n >= 1) && (n <= MAX_WORDS);
        s.push_back(n16[15:8]);
        s.push_back(n16[7:0]);
        if (len_ok) begin
            for (int i = 0; i < n; i++) begin
                w = words[i];
                s.push_back(w[31:24]);
                s.push_back(w[23:16]);
                s.push_back(w[15:8]);
                s.push_back(w[7:0]);
                x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                exp_q.push_back('{32'(i * 4), w});
            end
        end
        csum_byte = bad_csum ? (x ^ 8'h01) : x;
        if (CSUM_ON && len_ok) s.push_back(csum_byte);
        ok  = len_ok && !(CSUM_ON && bad_csum);
        lat = (!CSUM_ON && ok) ? 1 : 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("core_rst_after_start", {31'd0, core_rst_n}, 32'd0);
        chk("ready_after_start", {31'd0, bus.in_ready}, 32'd1);
        send(s, toggle);
        if (lat == 1) begin
            chk("done_during_fin", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("error", {31'd0, error}, {31'd0, !ok});
        chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, ok});
        chk("ready_end", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("pending_writes", exp_q.size(), 32'd0);
        if (len_ok && n >= 2) chk("write_gap", wr_gap, toggle ? 32'd8 : 32'd4);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [7:0]  s[$];
        int          n;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.imem_wr_en}, 32'd0);
        chk("rst_wr_addr", bus.imem_wr_addr, 32'd0);
        chk("rst_wr_data", bus.imem_wr_data, 32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("idle_core_rst_n", {31'd0, core_rst_n}, 32'd0);
            chk("idle_done_error", {30'd0, done, error}, 32'd0);
        end

        // Two-word image, back-to-back then with in_valid toggling
        wq.delete();
        wq.push_back(32'h20080005);
        wq.push_back(32'hAC010004);
        run_load(2, wq, 1'b0, 1'b0);
        run_load(2, wq, 1'b1, 1'b0);

        // Bytes offered in DONE are not consumed
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", {30'd0, done, bus.in_ready}, 32'd2);
        end
        bus.in_valid = 1'b0;

        // Bad lengths, then start clears error
        wq.delete();
        run_load(0, wq, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("error_cleared", {31'd0, error}, 32'd0);
        chk("ready_after_clear", {31'd0, bus.in_ready}, 32'd1);
        run_load(257, wq, 1'b0, 1'b0);

        // Checksum cases (plain one-word loads when the checksum is not compiled in)
        wq.push_back(32'h12345678);
        run_load(1, wq, 1'b0, 1'b0);
        run_load(1, wq, 1'b0, 1'b1);

        // Reset after three data bytes
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s.delete();
        s.push_back(8'h00);
        s.push_back(8'h02);
        s.push_back(8'h20);
        s.push_back(8'h08);
        s.push_back(8'h00);
        send(s, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("midrst_wr_en", {31'd0, bus.imem_wr_en}, 32'd0);
        chk("midrst_status", {29'd0, core_rst_n, done, error}, 32'd0);
        chk("midrst_wr_data", bus.imem_wr_data, 32'd0);
        wq.delete();
        wq.push_back(32'h20080005);
        wq.push_back(32'hAC010004);
        run_load(2, wq, 1'b0, 1'b0);

        // Largest accepted image
        wq.delete();
        for (int i = 0; i < MAX_WORDS; i++) wq.push_back($urandom);
        run_load(MAX_WORDS, wq, 1'b0, 1'b0);

        // Randomized loads
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 8);
            if ($urandom_range(0, 5) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_WORDS + 1, 600);
            wq.delete();
            for (int i = 0; i < 8; i++) wq.push_back($urandom);
            run_load(n, wq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
